pe_sequencer: RTL and testbench
===============================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of sample-count field and counter.
REQ-002 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have cfg_valid  input  1 / cfg_ready  output  1  job-command handshake.
REQ-005 SHALL have cfg_weight  input  8 / cfg_bias  input  8 / cfg_len  input  LEN_W  job weight, bias, sample count N.
REQ-006 SHALL have in_valid  input  1 / in_ready  output  1 / in_data  input  8  sample stream.
REQ-007 SHALL have res_valid  output  1 / res_ready  input  1 / res_data  output  16  result handshake.
REQ-008 SHALL have busy  output  1  high in every state except IDLE.
REQ-009 SHALL have PE-side outputs pe_data 8, pe_weight 8, pe_bias 8, pe_weight_en 1, pe_bias_en 1, pe_acc_en 1, and PE-side input pe_acc 16.

Function
REQ-010 SHALL implement states IDLE, LOAD, STREAM, WAIT, DONE.
REQ-011 IDLE: cfg_ready=1; on cfg_valid, register weight/bias/len, clear counter, go to LOAD.
REQ-012 LOAD: exactly one cycle with pe_weight_en=1 and pe_bias_en=1, pe_weight/pe_bias driven from registered values; next STREAM if N!=0, else WAIT.
REQ-013 STREAM: in_ready=1; each cycle with in_valid=1 SHALL assert pe_acc_en=1 with pe_data=in_data in that same cycle and increment counter.
REQ-014 STREAM: on acceptance of sample N (counter==N-1), go to WAIT; in_valid=0 cycles SHALL stall with pe_acc_en=0.
REQ-015 WAIT: one cycle; SHALL capture pe_acc into res_data at its closing edge; go to DONE.
REQ-016 DONE: res_valid=1, res_data held stable; on res_ready go to IDLE.
REQ-017 pe_acc_en and pe_bias_en SHALL never be high in the same cycle.
REQ-018 pe_data SHALL be 0 whenever pe_acc_en=0; all enables 0 outside LOAD/STREAM.
REQ-019 cfg_valid outside IDLE SHALL be ignored (cfg_ready=0); in_valid outside STREAM ignored (in_ready=0).
REQ-020 res_ready together with cfg_valid in DONE: cfg not accepted until the following IDLE cycle.
REQ-021 N=0: result SHALL equal sign-extended bias as reported by pe_acc.
REQ-022 Block SHALL perform no arithmetic on results; res_data is the captured pe_acc value verbatim.
REQ-023 Minimum job latency: cfg accept to res_valid = N+3 cycles with in_valid held high.

Reset
REQ-024 rst_n low SHALL immediately force IDLE; cfg_ready=1 after release, all other outputs 0, res_data=0, counter and job registers 0.
REQ-025 Reset mid-job SHALL discard the job with no further PE enables; downstream PE reset is assumed driven by the same rst_n.

Structure
REQ-026 Package systolic_pkg SHALL hold DATA_W=8, ACC_W=16 and the state enum typedef; pe_sequencer imports it.
REQ-027 No sub-module; single FSM plus counter; the PE is instantiated beside it at the next level up.

Verification
REQ-028 weight=3, bias=5, N=3, data 1,2,3 back-to-back -> res_data=0x0017, res_valid at cycle 6 after cfg accept.
REQ-029 N=0, bias=0xFB -> no pe_acc_en pulse, res_data=0xFFFB.
REQ-030 weight=2, bias=0, N=4, in_valid toggled 1,0,1,0 -> pe_acc_en only on valid cycles, res_data=2*(sum of samples).
REQ-031 res_ready held low 10 cycles in DONE -> res_valid and res_data stable; cfg_valid meanwhile ignored.
REQ-032 rst_n asserted mid-STREAM after 2 of 5 samples -> all outputs 0 immediately, IDLE after release, new job completes correctly.
REQ-033 Every test: assertion that pe_acc_en and pe_bias_en never coincide and pe_weight_en pulses once per job.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths and sequencer state encoding
//
// Purpose : common definitions for the systolic PE sequencer slice.
// Contents: DATA_W  - sample / weight / bias width
//           ACC_W   - PE accumulator width
//           state_t - sequencer FSM states
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pe_sequencer_if.sv
// rtl/pe_sequencer_if.sv - job, sample and result handshakes of the PE sequencer
//
// Purpose : bundles the host-facing handshakes of pe_sequencer.
// Signals : cfg_valid/cfg_ready, cfg_weight, cfg_bias, cfg_len - job command
//           in_valid/in_ready, in_data                         - sample stream
//           res_valid/res_ready, res_data                      - job result
//           busy                                               - sequencer not idle
// Modports: master - host side (issues jobs and samples, takes results)
//           slave  - sequencer side
interface pe_sequencer_if
  import systolic_pkg::*;
#(
  parameter int LEN_W = 8
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_weight;
  logic [DATA_W-1:0] cfg_bias;
  logic [LEN_W-1:0]  cfg_len;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  logic              busy;

  modport master (
    output cfg_valid, cfg_weight, cfg_bias, cfg_len,
    output in_valid, in_data,
    output res_ready,
    input  cfg_ready, in_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cfg_valid, cfg_weight, cfg_bias, cfg_len,
    input  in_valid, in_data,
    input  res_ready,
    output cfg_ready, in_ready, res_valid, res_data, busy
  );

endinterface

// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - drives one processing element through a weight/bias/stream job
//
// Purpose : accepts a job (weight, bias, sample count N), loads weight and bias
//           into the PE, streams N samples into its accumulator, then captures
//           the PE accumulator verbatim as the job result.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           bus (slave)      - cfg / in / res handshakes and busy
//           pe_data          - sample to the PE (0 unless pe_acc_en)
//           pe_weight        - weight to the PE (valid with pe_weight_en)
//           pe_bias          - bias to the PE (valid with pe_bias_en)
//           pe_weight_en     - PE weight load strobe
//           pe_bias_en       - PE accumulator preload with bias
//           pe_acc_en        - PE multiply-accumulate strobe
//           pe_acc           - PE accumulator value
module pe_sequencer
  import systolic_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_sequencer_if.slave     bus,
  output logic [DATA_W-1:0] pe_data,
  output logic [DATA_W-1:0] pe_weight,
  output logic [DATA_W-1:0] pe_bias,
  output logic              pe_weight_en,
  output logic              pe_bias_en,
  output logic              pe_acc_en,
  input  logic [ACC_W-1:0]  pe_acc
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] weight_q;
  logic [DATA_W-1:0] bias_q;
  logic [ACC_W-1:0]  res_q;
  logic              cfg_take;
  logic              acc_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_take) begin
        weight_q <= bus.cfg_weight;
        bias_q   <= bus.cfg_bias;
        len_q    <= bus.cfg_len;
        cnt_q    <= '0;
      end
      if (acc_take) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      // The PE finishes its last accumulate at the edge entering WAIT, so
      // pe_acc is final throughout WAIT and is taken at its closing edge.
      if (state_q == ST_WAIT) begin
        res_q <= pe_acc;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cfg_take      = 1'b0;
    acc_take      = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    pe_weight_en  = 1'b0;
    pe_bias_en    = 1'b0;
    pe_acc_en     = 1'b0;
    pe_weight     = '0;
    pe_bias       = '0;
    pe_data       = '0;

    case (state_q)
      ST_IDLE: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          cfg_take = 1'b1;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        pe_weight_en = 1'b1;
        pe_bias_en   = 1'b1;
        pe_weight    = weight_q;
        pe_bias      = bias_q;
        state_d      = (len_q != '0) ? ST_STREAM : ST_WAIT;
      end

      ST_STREAM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_take  = 1'b1;
          pe_acc_en = 1'b1;
          pe_data   = bus.in_data;
          // len_q is non-zero here, so len_q - 1 cannot wrap.
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.res_data = res_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - randomized self-checking bench for pe_sequencer
module tb_pe_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pe_data;
  logic [7:0]  pe_weight;
  logic [7:0]  pe_bias;
  logic        pe_weight_en;
  logic        pe_bias_en;
  logic        pe_acc_en;
  logic [15:0] pe_acc;
  logic [7:0]  pe_w_q;

  int n_cmp = 0;
  int n_bad = 0;

  pe_sequencer_if #(.LEN_W(8)) bus ();

  pe_sequencer #(.LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .pe_data      (pe_data),
    .pe_weight    (pe_weight),
    .pe_bias      (pe_bias),
    .pe_weight_en (pe_weight_en),
    .pe_bias_en   (pe_bias_en),
    .pe_acc_en    (pe_acc_en),
    .pe_acc       (pe_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processing element beside the sequencer: signed weight x sample MAC,
  // accumulator preloaded with the sign-extended bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_acc <= '0;
      pe_w_q <= '0;
    end else begin
      if (pe_weight_en) pe_w_q <= pe_weight;
      if (pe_bias_en) pe_acc <= {{8{pe_bias[7]}}, pe_bias};
      else if (pe_acc_en) pe_acc <= pe_acc + (16'($signed(pe_w_q)) * 16'($signed(pe_data)));
    end
  end

  // Every-cycle invariants on the PE-side strobes.
  always @(negedge clk) begin
    n_cmp++;
    if (pe_acc_en && pe_bias_en) begin
      n_bad++;
      $display("FAIL enable_overlap: acc_en=%b bias_en=%b, required never both 1", pe_acc_en, pe_bias_en);
    end
    n_cmp++;
    if (!pe_acc_en && pe_data !== 8'h00) begin
      n_bad++;
      $display("FAIL pe_data_idle: pe_data=%h, required 00 while acc_en=0", pe_data);
    end
    n_cmp++;
    if ((!bus.busy || bus.res_valid) && {pe_acc_en, pe_bias_en, pe_weight_en} !== 3'b000) begin
      n_bad++;
      $display("FAIL enables_outside_job: en=%b, required 000", {pe_acc_en, pe_bias_en, pe_weight_en});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected job result from the arithmetic definition of the PE job.
  function automatic logic [15:0] ref_result(input logic [7:0] w, input logic [7:0] b,
                                             input logic [7:0] data[$], input int n);
    int acc;
    acc = int'($signed(b));
    for (int i = 0; i < n; i++) acc += int'($signed(w)) * int'($signed(data[i]));
    return 16'(acc);
  endfunction

  // Issues one job and streams samples until res_valid is seen; leaves the
  // sequencer holding its result. mode 0: in_valid always 1, 1: toggling, 2: random.
  task automatic run_job(input logic [7:0] w, input logic [7:0] b, input logic [7:0] n,
                         input logic [7:0] data[$], input int mode,
                         output logic [15:0] res, output int lat, output int pulses,
                         output int wens, output int stalls, output bit data_ok,
                         output bit timeout);
    int idx;
    bit got;
    res = '0; lat = 0; pulses = 0; wens = 0; stalls = 0; data_ok = 1; timeout = 1;
    idx = 0; got = 0;
    step();
    bus.cfg_valid = 1'b1; bus.cfg_weight = w; bus.cfg_bias = b; bus.cfg_len = n;
    bus.res_ready = 1'b0; bus.in_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin got = 1; break; end
      step();
    end
    if (!got) begin
      bus.cfg_valid = 1'b0;
      return;
    end
    for (int k = 1; k < 400; k++) begin
      step();
      bus.cfg_valid = 1'b0;
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = ~k[0];
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = (idx < data.size()) ? data[idx] : 8'($urandom);
      @(negedge clk);
      if (bus.res_valid) begin
        res = bus.res_data; lat = k; timeout = 0;
        break;
      end
      if (pe_weight_en) wens++;
      if (pe_acc_en) pulses++;
      if (bus.in_ready) begin
        if (bus.in_valid) begin
          if (pe_acc_en !== 1'b1 || pe_data !== bus.in_data) data_ok = 0;
          idx++;
        end else begin
          stalls++;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic release_result();
    step();
    bus.res_ready = 1'b1;
    @(negedge clk);
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.res_valid, bus.in_ready} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: busy/res_valid/in_ready=%b, required 000", {bus.busy, bus.res_valid, bus.in_ready});
    end
    n_cmp++;
    if (bus.res_data !== 16'h0000) begin
      n_bad++; $display("FAIL reset_res_data: got %h, required 0000", bus.res_data);
    end
    n_cmp++;
    if ({pe_data, pe_weight, pe_bias, pe_weight_en, pe_bias_en, pe_acc_en} !== 27'd0) begin
      n_bad++; $display("FAIL reset_pe_outputs: got %h, required 0", {pe_data, pe_weight, pe_bias, pe_weight_en, pe_bias_en, pe_acc_en});
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: cfg_ready=%b busy=%b, required 1 0", bus.cfg_ready, bus.busy);
    end
  endtask

  task automatic test_basic_job();
    logic [7:0] q[$];
    logic [15:0] res; int lat, pulses, wens, stalls; bit ok, to;
    q = {8'd1, 8'd2, 8'd3};
    run_job(8'd3, 8'd5, 8'd3, q, 0, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== 16'h0017) begin
      n_bad++; $display("FAIL basic_result: got %h timeout=%0d, required 0017", res, to);
    end
    n_cmp++;
    if (lat !== 6) begin
      n_bad++; $display("FAIL basic_latency: got %0d, required 6", lat);
    end
    n_cmp++;
    if (pulses !== 3 || wens !== 1 || !ok) begin
      n_bad++; $display("FAIL basic_strobes: acc=%0d wen=%0d data_ok=%0d, required 3 1 1", pulses, wens, ok);
    end
    release_result();
  endtask

  task automatic test_zero_len();
    logic [7:0] q[$];
    logic [15:0] res; int lat, pulses, wens, stalls; bit ok, to;
    q = {};
    run_job(8'($urandom), 8'hFB, 8'd0, q, 0, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== 16'hFFFB) begin
      n_bad++; $display("FAIL zero_len_result: got %h timeout=%0d, required fffb", res, to);
    end
    n_cmp++;
    if (pulses !== 0 || wens !== 1 || lat !== 3) begin
      n_bad++; $display("FAIL zero_len_strobes: acc=%0d wen=%0d lat=%0d, required 0 1 3", pulses, wens, lat);
    end
    release_result();
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    logic [15:0] res; int lat, pulses, wens, stalls, sum; bit ok, to;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'($urandom_range(0, 60)));
      sum += int'(q[i]);
    end
    run_job(8'd2, 8'd0, 8'd4, q, 1, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== 16'(2 * sum)) begin
      n_bad++; $display("FAIL stall_result: got %h, required %h", res, 16'(2 * sum));
    end
    n_cmp++;
    if (pulses !== 4 || stalls !== 3 || !ok || lat !== 10) begin
      n_bad++; $display("FAIL stall_strobes: acc=%0d stalls=%0d data_ok=%0d lat=%0d, required 4 3 1 10", pulses, stalls, ok, lat);
    end
    release_result();
  endtask

  task automatic test_hold_done();
    logic [7:0] q[$];
    logic [15:0] res, exp; int lat, pulses, wens, stalls; bit ok, to, bad;
    logic [7:0] w, b;
    w = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    exp = ref_result(w, b, q, 5);
    run_job(w, b, 8'd5, q, 0, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== exp) begin
      n_bad++; $display("FAIL hold_result: got %h, required %h", res, exp);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.res_ready = 1'b0;
      bus.cfg_valid = 1'($urandom_range(0, 1));
      bus.cfg_len = 8'($urandom);
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.cfg_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL hold_stable: res_valid=%b res_data=%h cfg_ready=%b, required 1 %h 0", bus.res_valid, bus.res_data, bus.cfg_ready, exp);
    end
    step();
    bus.cfg_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_release: res_valid=%b busy=%b cfg_ready=%b, required 0 0 1", bus.res_valid, bus.busy, bus.cfg_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    logic [15:0] res, exp; int lat, pulses, wens, stalls; bit ok, to, bad;
    logic [7:0] w, b;
    bad = 0;
    step();
    bus.cfg_valid = 1'b1; bus.cfg_weight = 8'd7; bus.cfg_bias = 8'd9; bus.cfg_len = 8'd5;
    @(negedge clk);
    step();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      step();
      bus.in_valid = 1'b1; bus.in_data = 8'(s + 1);
      @(negedge clk);
      if (pe_acc_en !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL mid_reset_stream: acc_en=%b, required 1 on both samples", pe_acc_en);
    end
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.in_ready, bus.res_valid, pe_acc_en, pe_bias_en, pe_weight_en} !== 6'd0 || pe_data !== 8'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs: flags=%b pe_data=%h, required 0", {bus.busy, bus.in_ready, bus.res_valid, pe_acc_en, pe_bias_en, pe_weight_en}, pe_data);
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_data !== 16'h0000) begin
      n_bad++; $display("FAIL mid_reset_release: cfg_ready=%b busy=%b res=%h, required 1 0 0000", bus.cfg_ready, bus.busy, bus.res_data);
    end
    w = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    exp = ref_result(w, b, q, 5);
    run_job(w, b, 8'd5, q, 0, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== exp || lat !== 8 || wens !== 1) begin
      n_bad++; $display("FAIL mid_reset_new_job: res=%h lat=%0d wen=%0d, required %h 8 1", res, lat, wens, exp);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [15:0] res, exp; int lat, pulses, wens, stalls, n; bit ok, to;
    logic [7:0] w, b;
    for (int j = 0; j < 8; j++) begin
      q = {};
      w = 8'($urandom); b = 8'($urandom); n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      exp = ref_result(w, b, q, n);
      run_job(w, b, 8'(n), q, 2, res, lat, pulses, wens, stalls, ok, to);
      n_cmp++;
      if (to || res !== exp) begin
        n_bad++; $display("FAIL random_result job %0d: got %h, required %h", j, res, exp);
      end
      n_cmp++;
      if (pulses !== n || wens !== 1 || !ok || lat !== n + 3 + stalls) begin
        n_bad++; $display("FAIL random_strobes job %0d: acc=%0d wen=%0d ok=%0d lat=%0d, required %0d 1 1 %0d", j, pulses, wens, ok, lat, n, n + 3 + stalls);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q1[$], q2[$];
    logic [15:0] res, exp1, exp2; int lat, pulses, wens, stalls; bit ok, to;
    logic [7:0] w2, b2;
    for (int i = 0; i < 2; i++) q1.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) q2.push_back(8'($urandom));
    exp1 = ref_result(8'h11, 8'h80, q1, 2);
    w2 = 8'($urandom); b2 = 8'($urandom);
    exp2 = ref_result(w2, b2, q2, 4);
    run_job(8'h11, 8'h80, 8'd2, q1, 0, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== exp1) begin
      n_bad++; $display("FAIL b2b_first: got %h, required %h", res, exp1);
    end
    step();
    bus.res_ready = 1'b1;
    bus.cfg_valid = 1'b1; bus.cfg_weight = w2; bus.cfg_bias = b2; bus.cfg_len = 8'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.cfg_ready !== 1'b0 || bus.res_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_cfg_in_done: cfg_ready=%b res_valid=%b, required 0 1", bus.cfg_ready, bus.res_valid);
    end
    run_job(w2, b2, 8'd4, q2, 0, res, lat, pulses, wens, stalls, ok, to);
    n_cmp++;
    if (to || res !== exp2 || lat !== 7 || wens !== 1) begin
      n_bad++; $display("FAIL b2b_second: res=%h lat=%0d wen=%0d, required %h 7 1", res, lat, wens, exp2);
    end
    release_result();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_weight = '0; bus.cfg_bias = '0; bus.cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
    test_reset();
    test_basic_job();
    test_zero_len();
    test_stall();
    test_hold_done();
    test_reset_mid();
    test_random();
    test_back_to_back();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
